// File: rtl/pipe_hazard_unit_pkg.sv
// Shared pipeline-control types: FSM state encodings, forwarding-select encodings, control bundle.
// No logic; the EX-side operand muxes decode the same FWD_* values.
package pipe_hazard_unit_pkg;

  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_MWAIT  = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic bubble_idex;
    logic stall_all;
    logic flush;
    logic halted;
  } ctl_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Stage-register address/control taps into the hazard unit and the stall/flush/forward controls back out.
// master = pipeline datapath side, slave = hazard unit.
interface pipe_hazard_unit_if
  import pipe_hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic [REG_AW-1:0] ex_dst_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [REG_AW-1:0] mem_dst_addr;
  logic              mem_reg_write;
  logic              mem_redirect;
  logic              mem_halt;
  logic              dmem_busy;

  logic              stall_pc;
  logic              stall_ifid;
  logic              bubble_idex;
  logic              stall_all;
  logic              flush;
  fwd_sel_t          fwd_a_sel;
  fwd_sel_t          fwd_b_sel;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           ex_dst_addr, ex_reg_write, ex_mem_read,
           mem_dst_addr, mem_reg_write, mem_redirect, mem_halt, dmem_busy,
    input  stall_pc, stall_ifid, bubble_idex, stall_all, flush,
           fwd_a_sel, fwd_b_sel, halted, stall_cnt
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           ex_dst_addr, ex_reg_write, ex_mem_read,
           mem_dst_addr, mem_reg_write, mem_redirect, mem_halt, dmem_busy,
    output stall_pc, stall_ifid, bubble_idex, stall_all, flush,
           fwd_a_sel, fwd_b_sel, halted, stall_cnt
  );

endinterface

// File: rtl/dff.sv
// Generic enabled flop cell with async active-low reset to RST_VAL. Latency: 1 cycle.
// Backpressure: en=0 holds the current value.
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_fwd_sel.sv
// Forwarding-source compare for one decode operand. Latency: combinational.
// Backpressure: none; the caller decides when the result is latched.
module pipe_fwd_sel
  import pipe_hazard_unit_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_used,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_dst_addr,
  input  logic              mem_reg_write,
  output fwd_sel_t          sel
);

  // The EX producer is checked first: it is the nearer one once the consumer reaches EX.
  always_comb begin
    sel = FWD_RF;
    if (src_used) begin
      if (ex_reg_write && !ex_mem_read && (src_addr == ex_dst_addr)) begin
        sel = FWD_MEM;
      end else if (mem_reg_write && (src_addr == mem_dst_addr)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard control: stall/bubble/flush decode, registered forwarding selects, stall counter.
// Latency: controls combinational in the current cycle, selects 1 cycle; dmem_busy stalls from the next cycle.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_unit_if.slave hz
);

  logic [1:0]       state_bits;
  state_t           state_q;
  state_t           state_d;
  ctl_t             ctl;
  logic             load_use;
  fwd_sel_t         sel_a_new;
  fwd_sel_t         sel_b_new;
  fwd_sel_t         sel_a_d;
  fwd_sel_t         sel_b_d;
  fwd_sel_t         sel_a_q;
  fwd_sel_t         sel_b_q;
  logic             sel_en;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign state_q = state_t'(state_bits);

  assign load_use = hz.ex_mem_read & hz.ex_reg_write &
                    ((hz.id_rs_used & (hz.id_rs_addr == hz.ex_dst_addr)) |
                     (hz.id_rt_used & (hz.id_rt_addr == hz.ex_dst_addr)));

  // A busy memory seen in RUN only registers the wait; the freeze starts in MWAIT.
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    unique case (state_q)
      ST_RUN: begin
        if (hz.dmem_busy) begin
          state_d = ST_MWAIT;
        end else if (hz.mem_halt) begin
          state_d = ST_DRAIN;
        end else if (hz.mem_redirect) begin
          ctl.flush = 1'b1;
        end else if (load_use) begin
          ctl.stall_pc    = 1'b1;
          ctl.stall_ifid  = 1'b1;
          ctl.bubble_idex = 1'b1;
        end
      end
      ST_MWAIT: begin
        ctl.stall_all  = 1'b1;
        ctl.stall_pc   = 1'b1;
        ctl.stall_ifid = 1'b1;
        if (!hz.dmem_busy) begin
          state_d = hz.mem_halt ? ST_DRAIN : ST_RUN;
        end
      end
      ST_DRAIN: begin
        ctl.stall_pc    = 1'b1;
        ctl.stall_ifid  = 1'b1;
        ctl.bubble_idex = 1'b1;
        state_d         = ST_HALTED;
      end
      ST_HALTED: begin
        ctl.stall_all  = 1'b1;
        ctl.stall_pc   = 1'b1;
        ctl.stall_ifid = 1'b1;
        ctl.halted     = 1'b1;
      end
    endcase
    if (!rst) begin
      ctl = '0;
    end
  end

  pipe_fwd_sel u_fwd_a (
    .src_addr      (hz.id_rs_addr),
    .src_used      (hz.id_rs_used),
    .ex_dst_addr   (hz.ex_dst_addr),
    .ex_reg_write  (hz.ex_reg_write),
    .ex_mem_read   (hz.ex_mem_read),
    .mem_dst_addr  (hz.mem_dst_addr),
    .mem_reg_write (hz.mem_reg_write),
    .sel           (sel_a_new)
  );

  pipe_fwd_sel u_fwd_b (
    .src_addr      (hz.id_rt_addr),
    .src_used      (hz.id_rt_used),
    .ex_dst_addr   (hz.ex_dst_addr),
    .ex_reg_write  (hz.ex_reg_write),
    .ex_mem_read   (hz.ex_mem_read),
    .mem_dst_addr  (hz.mem_dst_addr),
    .mem_reg_write (hz.mem_reg_write),
    .sel           (sel_b_new)
  );

  // Selects track ID/EX: frozen with the pipe, cleared when a NOP enters EX.
  assign sel_en  = ~ctl.stall_all;
  assign sel_a_d = (ctl.bubble_idex | ctl.flush) ? FWD_RF : sel_a_new;
  assign sel_b_d = (ctl.bubble_idex | ctl.flush) ? FWD_RF : sel_b_new;

  assign cnt_en = ctl.stall_pc & (state_q != ST_HALTED) & ~(&cnt_q);
  assign cnt_d  = cnt_q + CNT_W'(1);

  dff #(.W(2)) u_state_ff (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (state_d),
    .q   (state_bits)
  );

  dff #(.W(2)) u_sel_a_ff (
    .clk (clk),
    .rst (rst),
    .en  (sel_en),
    .d   (sel_a_d),
    .q   (sel_a_q)
  );

  dff #(.W(2)) u_sel_b_ff (
    .clk (clk),
    .rst (rst),
    .en  (sel_en),
    .d   (sel_b_d),
    .q   (sel_b_q)
  );

  dff #(.W(CNT_W)) u_cnt_ff (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .d   (cnt_d),
    .q   (cnt_q)
  );

  assign hz.stall_pc    = ctl.stall_pc;
  assign hz.stall_ifid  = ctl.stall_ifid;
  assign hz.bubble_idex = ctl.bubble_idex;
  assign hz.stall_all   = ctl.stall_all;
  assign hz.flush       = ctl.flush;
  assign hz.halted      = ctl.halted;
  assign hz.fwd_a_sel   = sel_a_q;
  assign hz.fwd_b_sel   = sel_b_q;
  assign hz.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed-vector bench for pipe_hazard_unit: hazards, forwarding, memory wait, halt, async reset, counter saturation.
module tb_pipe_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.CNT_W(16)) hz ();

  pipe_hazard_unit #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Order: {stall_pc, stall_ifid, bubble_idex, stall_all, flush}
  task automatic chk_ctl(input string tag, input logic [4:0] want);
    check_val(tag, 32'({hz.stall_pc, hz.stall_ifid, hz.bubble_idex, hz.stall_all, hz.flush}),
              32'(want));
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] want_a, input logic [1:0] want_b);
    check_val({tag, "_a"}, 32'(hz.fwd_a_sel), 32'(want_a));
    check_val({tag, "_b"}, 32'(hz.fwd_b_sel), 32'(want_b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [2:0] rs, input logic rs_used, input logic [2:0] rt, input logic rt_used);
    hz.id_rs_addr = rs;
    hz.id_rs_used = rs_used;
    hz.id_rt_addr = rt;
    hz.id_rt_used = rt_used;
  endtask

  task automatic set_ex(input logic [2:0] dst, input logic wr, input logic ld);
    hz.ex_dst_addr  = dst;
    hz.ex_reg_write = wr;
    hz.ex_mem_read  = ld;
  endtask

  task automatic set_mem(input logic [2:0] dst, input logic wr);
    hz.mem_dst_addr  = dst;
    hz.mem_reg_write = wr;
  endtask

  task automatic idle();
    set_id(3'd0, 1'b0, 3'd0, 1'b0);
    set_ex(3'd0, 1'b0, 1'b0);
    set_mem(3'd0, 1'b0);
    hz.mem_redirect = 1'b0;
    hz.mem_halt     = 1'b0;
    hz.dmem_busy    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    exp_cnt = 16'd0;
    #1 rst = 1'b0;
    #1;
    chk_ctl("rst_ctl", 5'b00000);
    chk_sel("rst_sel", 2'b00, 2'b00);
    check_val("rst_halted", 32'(hz.halted), 0);
    check_val("rst_cnt", 32'(hz.stall_cnt), 0);
    set_ex(3'd3, 1'b1, 1'b1);
    set_id(3'd3, 1'b1, 3'd0, 1'b0);
    hz.mem_redirect = 1'b1;
    #1 chk_ctl("rst_gate", 5'b00000);
    idle();
    rst = 1'b1;
    tick();

    // Forwarding: nearest producer, r0 as a normal register, unused operand
    set_ex(3'd5, 1'b1, 1'b0); set_mem(3'd5, 1'b1); set_id(3'd0, 1'b1, 3'd5, 1'b1);
    #1 chk_ctl("alu_noload", 5'b00000);
    tick(); chk_sel("fwd_v1", 2'b00, 2'b01);
    set_ex(3'd0, 1'b1, 1'b0); set_mem(3'd5, 1'b1); set_id(3'd0, 1'b1, 3'd5, 1'b1);
    tick(); chk_sel("fwd_v2", 2'b01, 2'b10);
    set_id(3'd0, 1'b1, 3'd5, 1'b0);
    tick(); chk_sel("fwd_v3", 2'b01, 2'b00);

    // Redirect beats a simultaneous load-use and clears the selects
    set_ex(3'd0, 1'b1, 1'b1); set_mem(3'd5, 1'b1); set_id(3'd0, 1'b1, 3'd5, 1'b1);
    hz.mem_redirect = 1'b1;
    #1 chk_ctl("redir_lu", 5'b00001);
    tick(); chk_sel("redir", 2'b00, 2'b00);

    // Load-use on Rs, then the load sits in MEM
    idle();
    set_ex(3'd3, 1'b1, 1'b1); set_id(3'd3, 1'b1, 3'd0, 1'b0);
    #1 chk_ctl("lu_rs", 5'b11100);
    tick(); exp_cnt = 16'd1;
    check_val("lu_bubble_a", 32'(hz.fwd_a_sel), 0);
    set_ex(3'd0, 1'b0, 1'b0); set_mem(3'd3, 1'b1);
    #1 chk_ctl("lu_after", 5'b00000);
    tick(); check_val("lu_fwd_a", 32'(hz.fwd_a_sel), 2);

    set_ex(3'd6, 1'b1, 1'b1); set_mem(3'd0, 1'b0); set_id(3'd6, 1'b0, 3'd6, 1'b1);
    #1 chk_ctl("lu_rt", 5'b11100);
    tick(); exp_cnt = 16'd2;
    set_id(3'd6, 1'b0, 3'd6, 1'b0);
    #1 chk_ctl("lu_unused", 5'b00000);
    set_ex(3'd6, 1'b0, 1'b1); set_id(3'd6, 1'b1, 3'd6, 1'b1);
    #1 chk_ctl("lu_nowr", 5'b00000);
    tick(); check_val("lu_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));

    // Memory wait: busy for 3 cycles, selects frozen
    set_ex(3'd2, 1'b1, 1'b0); set_mem(3'd3, 1'b1); set_id(3'd3, 1'b1, 3'd2, 1'b1);
    tick(); chk_sel("busy_setup", 2'b10, 2'b01);
    hz.dmem_busy = 1'b1;
    #1 chk_ctl("busy_enter", 5'b00000);
    tick();
    set_id(3'd0, 1'b0, 3'd0, 1'b0);
    #1 chk_ctl("mwait1", 5'b11010);
    tick(); exp_cnt = 16'd3;
    tick(); exp_cnt = 16'd4;
    hz.dmem_busy = 1'b0;
    #1 chk_ctl("mwait_exit", 5'b11010);
    tick(); exp_cnt = 16'd5;
    chk_sel("busy_hold", 2'b10, 2'b01);
    chk_ctl("busy_done", 5'b00000);
    check_val("busy_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));

    // Halt: DRAIN for one cycle, then HALTED sticks
    idle();
    hz.mem_halt = 1'b1;
    #1 chk_ctl("halt_run", 5'b00000);
    tick();
    hz.mem_halt = 1'b0;
    #1 chk_ctl("drain", 5'b11100);
    check_val("drain_halted", 32'(hz.halted), 0);
    tick(); exp_cnt = 16'd6;
    check_val("halted", 32'(hz.halted), 1);
    hz.mem_redirect = 1'b1;
    #1 chk_ctl("halted_ctl", 5'b11010);
    repeat (3) tick();
    check_val("halted_keep", 32'(hz.halted), 1);
    check_val("halted_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));

    rst = 1'b0;
    #1;
    check_val("rst2_halted", 32'(hz.halted), 0);
    chk_ctl("rst2_ctl", 5'b00000);
    check_val("rst2_cnt", 32'(hz.stall_cnt), 0);
    idle();
    rst = 1'b1;
    tick();

    // Busy together with halt: wait first, then drain
    hz.dmem_busy = 1'b1; hz.mem_halt = 1'b1;
    #1 chk_ctl("bh_run", 5'b00000);
    tick();
    hz.dmem_busy = 1'b0;
    #1 chk_ctl("bh_mwait", 5'b11010);
    tick();
    hz.mem_halt = 1'b0;
    #1 chk_ctl("bh_drain", 5'b11100);
    tick();
    check_val("bh_halted", 32'(hz.halted), 1);
    check_val("bh_cnt", 32'(hz.stall_cnt), 2);

    rst = 1'b0;
    #1 rst = 1'b1;
    idle();

    // Async reset in the middle of a memory wait
    hz.dmem_busy = 1'b1;
    tick();
    tick();
    #1 chk_ctl("pre_rst", 5'b11010);
    check_val("pre_rst_cnt", 32'(hz.stall_cnt), 1);
    #2 rst = 1'b0;
    #1 chk_ctl("async_rst", 5'b00000);
    check_val("async_rst_cnt", 32'(hz.stall_cnt), 0);
    check_val("async_rst_halted", 32'(hz.halted), 0);
    rst = 1'b1;

    // Long wait drives the counter to saturation
    tick();
    chk_ctl("sat_mwait", 5'b11010);
    repeat (65534) tick();
    check_val("sat_fffe", 32'(hz.stall_cnt), 32'h0000_FFFE);
    tick();
    check_val("sat_ffff", 32'(hz.stall_cnt), 32'h0000_FFFF);
    repeat (4) tick();
    check_val("sat_hold", 32'(hz.stall_cnt), 32'h0000_FFFF);
    hz.dmem_busy = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
